// File: rtl/row_stream_tx.sv
// Row-stream transmitter: buffers pushed pixel words and emits vsync / per-row hsync framed bursts.
// Optional statistics outputs (o_frame_cnt, o_stall) are built when ROW_TX_STAT_EN is defined.
module row_stream_tx #(
   parameter int WIDTH_D = 27,
   parameter int SIZE    = 28,
   parameter int CHANNEL = 4,
   parameter int GAP     = 0,
   parameter int PADWAIT = 21,
   parameter int DEPTH   = 256
) (
   input  logic               i_sclk,
   input  logic               i_rst,
   input  logic               i_vsync,
   input  logic               i_valid,
   input  logic [WIDTH_D-1:0] i_tdata,
   output logic               o_ready,
   output logic               o_vsync,
   output logic               o_hsync,
   output logic               o_reuse,
   output logic               o_valid,
   output logic [WIDTH_D-1:0] o_tdata
`ifdef ROW_TX_STAT_EN
   ,
   output logic [15:0]        o_frame_cnt,
   output logic               o_stall
`endif
);

   localparam int ROW_LEN = SIZE * CHANNEL;
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int BW = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
   localparam int RW = $clog2(SIZE + 1);
   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
   localparam int PW = (PADWAIT > 1) ? $clog2(PADWAIT) : 1;

   localparam logic [CW-1:0] ROW_LEN_C = CW'(ROW_LEN);
   localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
   localparam logic [AW-1:0] PTR_LAST  = AW'(DEPTH - 1);
   localparam logic [BW-1:0] BEAT_LAST = BW'(ROW_LEN - 1);
   localparam logic [RW-1:0] SIZE_C    = RW'(SIZE);
   localparam logic [GW-1:0] GAP_LAST  = GW'((GAP > 0) ? GAP - 1 : 0);
   localparam logic [PW-1:0] PAD_LAST  = PW'((PADWAIT > 0) ? PADWAIT - 1 : 0);

   generate
      if (DEPTH < ROW_LEN) begin : g_depth_chk
         $error("row_stream_tx: DEPTH must be at least SIZE*CHANNEL");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_IDLE,
      S_VS,
      S_HS,
      S_GAPW,
      S_ROW,
      S_PADW,
      S_WAIT
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;

   logic [WIDTH_D-1:0]   r_mem [DEPTH];
   logic [AW-1:0]        r_wr_ptr;
   logic [AW-1:0]        r_rd_ptr;
   logic [CW-1:0]        r_count;
   logic                 r_ready;

   logic [BW-1:0]        r_beat;
   logic [RW-1:0]        r_row;
   logic [GW-1:0]        r_gap;
   logic [PW-1:0]        r_pad;

   logic                 r_vsync;
   logic                 r_hsync;
   logic                 r_reuse;
   logic                 r_valid;
   logic [WIDTH_D-1:0]   r_tdata;

   logic                 w_flush;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_row_ready;
   logic                 w_pad_done;
   logic [CW-1:0]        w_count_nxt;
   logic                 w_vsync_nxt;
   logic                 w_hsync_nxt;
   logic                 w_reuse_nxt;
   logic [WIDTH_D-1:0]   w_tdata_nxt;

   assign w_flush     = i_rst | i_vsync;
   assign w_push      = i_valid & r_ready & ~w_flush;
   assign w_row_ready = (r_count >= ROW_LEN_C);
   // PADWAIT of 0 or 1 still spends one cycle in PADW before deciding.
   assign w_pad_done  = (PADWAIT <= 1) || (r_pad == PAD_LAST);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (w_row_ready) w_state_nxt = S_VS;
         S_VS:   w_state_nxt = S_HS;
         S_HS:   w_state_nxt = (GAP == 0) ? S_ROW : S_GAPW;
         S_GAPW: if (r_gap == GAP_LAST) w_state_nxt = S_ROW;
         S_ROW:  if (r_beat == BEAT_LAST) w_state_nxt = S_PADW;
         S_PADW: begin
            if (w_pad_done) begin
               if (r_row == SIZE_C)  w_state_nxt = S_IDLE;
               else if (w_row_ready) w_state_nxt = S_HS;
               else                  w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: if (w_row_ready) w_state_nxt = S_HS;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Popping one cycle ahead of ROW lets the registered data line up with o_valid.
   always_comb begin
      w_pop       = (w_state_nxt == S_ROW);
      w_vsync_nxt = (w_state_nxt == S_VS);
      w_hsync_nxt = (w_state_nxt == S_HS);
      w_reuse_nxt = w_pop && (r_row != '0);
      w_tdata_nxt = w_pop ? r_mem[r_rd_ptr] : '0;
      w_count_nxt = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + 1'b1;
         2'b01:   w_count_nxt = r_count - 1'b1;
         default: w_count_nxt = r_count;
      endcase
   end

   always_ff @(posedge i_sclk) begin
      if (w_flush) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_ff @(posedge i_sclk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_tdata;
   end

   always_ff @(posedge i_sclk) begin
      if (w_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_ready  <= 1'b1;
         r_beat   <= '0;
         r_row    <= '0;
         r_gap    <= '0;
         r_pad    <= '0;
         r_vsync  <= 1'b0;
         r_hsync  <= 1'b0;
         r_reuse  <= 1'b0;
         r_valid  <= 1'b0;
         r_tdata  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
         r_count <= w_count_nxt;
         r_ready <= (w_count_nxt < DEPTH_C);

         r_beat <= (r_state == S_ROW)  ? r_beat + 1'b1 : '0;
         r_gap  <= (r_state == S_GAPW) ? r_gap + 1'b1  : '0;
         r_pad  <= (r_state == S_PADW) ? r_pad + 1'b1  : '0;
         if (r_state == S_VS)
            r_row <= '0;
         else if ((r_state == S_ROW) && (r_beat == BEAT_LAST))
            r_row <= r_row + 1'b1;

         r_vsync <= w_vsync_nxt;
         r_hsync <= w_hsync_nxt;
         r_reuse <= w_reuse_nxt;
         r_valid <= w_pop;
         r_tdata <= w_tdata_nxt;
      end
   end

   assign o_ready = r_ready;
   assign o_vsync = r_vsync;
   assign o_hsync = r_hsync;
   assign o_reuse = r_reuse;
   assign o_valid = r_valid;
   assign o_tdata = r_tdata;

`ifdef ROW_TX_STAT_EN
   logic [15:0] r_frame_cnt;
   logic        r_stall;
   logic        w_frame_done;
   logic        w_stall_set;

   assign w_frame_done = (r_state == S_PADW) && (w_state_nxt == S_IDLE);
   assign w_stall_set  = (r_state != S_WAIT) && (w_state_nxt == S_WAIT);

   // Statistics survive an upstream vsync flush; only a hard reset clears them.
   always_ff @(posedge i_sclk) begin
      if (i_rst) begin
         r_frame_cnt <= '0;
         r_stall     <= 1'b0;
      end else if (!i_vsync) begin
         if (w_frame_done) r_frame_cnt <= r_frame_cnt + 1'b1;
         if (w_stall_set)  r_stall     <= 1'b1;
      end
   end

   assign o_frame_cnt = r_frame_cnt;
   assign o_stall     = r_stall;
`endif

endmodule

// File: tb/tb_row_stream_tx.sv
// Scoreboard bench for row_stream_tx (SIZE=4, CHANNEL=2, GAP=2, PADWAIT=3, DEPTH=16).
// Framing, data order, reuse flag and the optional ROW_TX_STAT_EN counters are checked.
module tb_row_stream_tx;

   localparam int W     = 27;
   localparam int RL    = 8;
   localparam int FRAME = 32;

   typedef struct packed {
      logic         reuse;
      logic [W-1:0] data;
   } exp_t;

   logic          i_sclk;
   logic          i_rst;
   logic          i_vsync;
   logic          i_valid;
   logic [W-1:0]  i_tdata;
   logic          o_ready;
   logic          o_vsync;
   logic          o_hsync;
   logic          o_reuse;
   logic          o_valid;
   logic [W-1:0]  o_tdata;
`ifdef ROW_TX_STAT_EN
   logic [15:0]   o_frame_cnt;
   logic          o_stall;
`endif

   row_stream_tx #(
      .WIDTH_D (W),
      .SIZE    (4),
      .CHANNEL (2),
      .GAP     (2),
      .PADWAIT (3),
      .DEPTH   (16)
   ) dut (
      .i_sclk      (i_sclk),
      .i_rst       (i_rst),
      .i_vsync     (i_vsync),
      .i_valid     (i_valid),
      .i_tdata     (i_tdata),
      .o_ready     (o_ready),
      .o_vsync     (o_vsync),
      .o_hsync     (o_hsync),
      .o_reuse     (o_reuse),
      .o_valid     (o_valid),
      .o_tdata     (o_tdata)
`ifdef ROW_TX_STAT_EN
      ,
      .o_frame_cnt (o_frame_cnt),
      .o_stall     (o_stall)
`endif
   );

   initial i_sclk = 1'b0;
   always #5 i_sclk = ~i_sclk;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb_q[$];
   int   sb_pos   = 0;

   int   mon_cyc         = 0;
   int   mon_vs          = 0;
   int   mon_hs          = 0;
   int   mon_total       = 0;
   int   mon_frame_beats = 0;
   int   mon_row_beats   = 0;
   int   mon_hs_cyc      = 0;
   int   mon_last_valid  = 0;
   bit   mon_first_row   = 1'b1;
   bit   mon_saw_full    = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge i_sclk);
      #1;
   endtask

   task automatic push_word(input logic [W-1:0] d);
      bit   rdy;
      int   tries;
      exp_t e;
      tries   = 0;
      i_valid = 1'b1;
      i_tdata = d;
      do begin
         rdy = o_ready;
         tick();
         tries++;
      end while (!rdy && tries < 200);
      i_valid = 1'b0;
      i_tdata = '0;
      if (rdy) begin
         e.reuse = ((sb_pos % FRAME) >= RL);
         e.data  = d;
         sb_q.push_back(e);
         sb_pos++;
      end else begin
         check_eq("push_timeout", 32'(rdy), 32'd1);
      end
   endtask

   task automatic drain(input int budget);
      for (int i = 0; i < budget && sb_q.size() != 0; i++) tick();
      check_eq("drain", 32'(sb_q.size()), 32'd0);
   endtask

   task automatic wait_beats(input int k, input int budget);
      for (int i = 0; i < budget && mon_frame_beats < k; i++) tick();
      check_eq("wait_beats", 32'(mon_frame_beats), 32'(k));
   endtask

   task automatic check_quiet(input string tag);
      check_eq({tag, "_ready"}, 32'(o_ready), 32'd1);
      check_eq({tag, "_vsync"}, 32'(o_vsync), 32'd0);
      check_eq({tag, "_hsync"}, 32'(o_hsync), 32'd0);
      check_eq({tag, "_valid"}, 32'(o_valid), 32'd0);
      check_eq({tag, "_reuse"}, 32'(o_reuse), 32'd0);
      check_eq({tag, "_tdata"}, 32'(o_tdata), 32'd0);
   endtask

   // Output monitor: pops the scoreboard on every beat and checks row framing.
   initial begin
      exp_t e;
      forever begin
         @(negedge i_sclk);
         mon_cyc++;
         if (i_rst || i_vsync) begin
            sb_q.delete();
            mon_frame_beats = 0;
            mon_row_beats   = 0;
            mon_first_row   = 1'b1;
         end else begin
            if (!o_ready) mon_saw_full = 1'b1;
            if (o_vsync) begin
               mon_vs++;
               mon_frame_beats = 0;
               mon_first_row   = 1'b1;
            end
            if (o_hsync) begin
               mon_hs++;
               if (!mon_first_row) begin
                  check_eq("row_len", 32'(mon_row_beats), 32'(RL));
                  check_eq("pad_gap_ge4", 32'((mon_cyc - mon_last_valid) >= 4), 32'd1);
               end
               mon_first_row = 1'b0;
               mon_row_beats = 0;
               mon_hs_cyc    = mon_cyc;
            end
            if (o_valid) begin
               if (mon_row_beats == 0)
                  check_eq("hs_to_beat", 32'(mon_cyc - mon_hs_cyc), 32'd3);
               if (sb_q.size() == 0) begin
                  check_eq("sb_nonempty", 32'(sb_q.size()), 32'd1);
               end else begin
                  e = sb_q.pop_front();
                  check_eq("data", 32'(o_tdata), 32'(e.data));
                  check_eq("reuse", 32'(o_reuse), 32'(e.reuse));
               end
               mon_row_beats++;
               mon_frame_beats++;
               mon_total++;
               mon_last_valid = mon_cyc;
            end else begin
               check_eq("tdata_idle", 32'(o_tdata), 32'd0);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int vs0;
      int hs0;
      int tot0;

      i_rst   = 1'b1;
      i_vsync = 1'b0;
      i_valid = 1'b0;
      i_tdata = '0;
      repeat (3) tick();
      i_rst = 1'b0;
      check_quiet("reset");
`ifdef ROW_TX_STAT_EN
      check_eq("reset_frame_cnt", 32'(o_frame_cnt), 32'd0);
      check_eq("reset_stall", 32'(o_stall), 32'd0);
`endif

      // Full frame pushed back-to-back; FIFO back-pressure must appear.
      vs0  = mon_vs;
      hs0  = mon_hs;
      tot0 = mon_total;
      for (int i = 1; i <= 32; i++) push_word(W'(i));
      drain(500);
      repeat (8) tick();
      check_eq("A_vsync_cnt", 32'(mon_vs - vs0), 32'd1);
      check_eq("A_hsync_cnt", 32'(mon_hs - hs0), 32'd4);
      check_eq("A_beats", 32'(mon_total - tot0), 32'd32);
      check_eq("A_saw_not_ready", 32'(mon_saw_full), 32'd1);
      check_quiet("A_idle");

      // Seven words must not start a frame; the eighth does one cycle later.
      vs0 = mon_vs;
      for (int i = 1; i <= 7; i++) push_word(W'(100 + i));
      repeat (10) tick();
      check_eq("B_no_vsync", 32'(mon_vs - vs0), 32'd0);
      push_word(W'(108));
      check_eq("B_vsync_early", 32'(o_vsync), 32'd0);
      tick();
      check_eq("B_vsync_lat", 32'(o_vsync), 32'd1);

      // Row 0 drains the FIFO, the FSM parks in WAIT until the next row is buffered.
      wait_beats(8, 100);
      repeat (20) tick();
      check_eq("C_valid_wait", 32'(o_valid), 32'd0);
`ifdef ROW_TX_STAT_EN
      check_eq("C_stall", 32'(o_stall), 32'd1);
`endif
      for (int i = 1; i <= 8; i++) push_word(W'(120 + i));
      check_eq("C_hsync_early", 32'(o_hsync), 32'd0);
      tick();
      check_eq("C_hsync_lat", 32'(o_hsync), 32'd1);
      for (int i = 1; i <= 16; i++) push_word(W'(140 + i));
      drain(500);
      repeat (10) tick();

      // Upstream vsync on beat 4 of row 1 flushes everything.
      for (int i = 1; i <= 16; i++) push_word(W'(200 + i));
      wait_beats(12, 300);
      i_vsync = 1'b1;
      tick();
      i_vsync = 1'b0;
      sb_pos  = 0;
      check_quiet("E_flush");
      vs0 = mon_vs;
      for (int i = 1; i <= 8; i++) push_word(W'(300 + i));
      wait_beats(8, 100);
      check_eq("E_restart_vsync", 32'(mon_vs - vs0), 32'd1);
      for (int i = 9; i <= 32; i++) push_word(W'(300 + i));
      drain(500);
      repeat (10) tick();
`ifdef ROW_TX_STAT_EN
      check_eq("F_frames_before", 32'(o_frame_cnt), 32'd3);
`endif

      // Reset during PADW after row 0, then two complete frames.
      for (int i = 1; i <= 16; i++) push_word(W'(400 + i));
      wait_beats(8, 100);
      tick();
      i_rst = 1'b1;
      tick();
      i_rst  = 1'b0;
      sb_pos = 0;
      check_quiet("F_reset");
`ifdef ROW_TX_STAT_EN
      check_eq("F_reset_frame_cnt", 32'(o_frame_cnt), 32'd0);
      check_eq("F_reset_stall", 32'(o_stall), 32'd0);
`endif
      vs0 = mon_vs;
      for (int i = 1; i <= 64; i++) push_word(W'(500 + i));
      drain(800);
      repeat (10) tick();
      check_eq("F_vsync_cnt", 32'(mon_vs - vs0), 32'd2);
`ifdef ROW_TX_STAT_EN
      check_eq("F_frame_cnt", 32'(o_frame_cnt), 32'd2);
      check_eq("F_stall", 32'(o_stall), 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
